stream_rr_arbiter: RTL

// - N_CH-channel valid/ready stream arbiter: round-robin merges N_CH input streams into one registered output.
// - Generalises the fixed single-instance pattern to a channel array with per-channel handshake and output channel tag.
// - Sits between multiple request sources and one shared consumer, for example a bus master port or a shared FIFO.

---
 rtl/stream_rr_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: round-robin merge of N_CH valid/ready streams into one registered output slice.
// Optional packet lock is enabled by defining STREAM_RR_ARBITER_PKT_LOCK_EN. When it is defined, a granted
// channel keeps the grant until it sends a beat with last=1.
module stream_rr_arbiter #(
  parameter int N_CH = 4,
  parameter int WIDTH = 32,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [N_CH-1:0]         i_in_valid,
  output logic [N_CH-1:0]         o_in_ready,
  input  logic [N_CH*WIDTH-1:0]   i_in_data,
  input  logic [N_CH-1:0]         i_in_last,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic [WIDTH-1:0]        o_out_data,
  output logic                    o_out_last,
  output logic [CH_W-1:0]         o_out_ch
);
  localparam logic [CH_W:0]   N_CH_L  = (CH_W+1)'(N_CH);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH-1);
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [N_CH-1:0]   elig;
  logic [N_CH-1:0]   in_ready;
  logic [CH_W-1:0]   grant;
  logic [CH_W:0]     sum;
  logic              found;
  logic              load;
  logic              fire;
  logic [WIDTH-1:0]  sel_data;
  logic              sel_last;
`ifdef STREAM_RR_ARBITER_PKT_LOCK_EN
  logic              lock_q, lock_d;
  logic [CH_W-1:0]   lock_ch_q, lock_ch_d;
  logic [N_CH-1:0]   lock_mask;
  assign lock_mask = N_CH'(1) << lock_ch_q;
  assign elig      = lock_q ? (i_in_valid & lock_mask) : i_in_valid;
`else
  assign elig      = i_in_valid;
`endif
  assign load  = !out_valid_q || i_out_ready;
  assign fire  = load && found;
  // Search eligible channels starting at ptr and wrapping at N_CH; the first hit wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    sum   = '0;
    for (int i = 0; i < N_CH; i++) begin
      sum = {1'b0, ptr_q} + (CH_W+1)'(i);
      if (sum >= N_CH_L) sum = sum - N_CH_L;
      if (!found && elig[sum[CH_W-1:0]]) begin
        found = 1'b1;
        grant = sum[CH_W-1:0];
      end
    end
  end
  // Steer the granted channel's beat to the output and raise only its ready.
  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    in_ready = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant == CH_W'(i)) begin
        sel_data    = i_in_data[i*WIDTH +: WIDTH];
        sel_last    = i_in_last[i];
        in_ready[i] = fire;
      end
    end
  end
  assign o_in_ready = in_ready;
  // Output slice refills whenever it is empty or being drained; the pointer moves past the winner.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (load) out_valid_d = found;
    if (fire) begin
      out_data_d = sel_data;
      out_last_d = sel_last;
      out_ch_d   = grant;
      ptr_d      = (grant == LAST_CH) ? '0 : grant + CH_W'(1);
    end
  end
  // Output and pointer registers, cleared immediately by reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end
`ifdef STREAM_RR_ARBITER_PKT_LOCK_EN
  // A non-final beat pins the grant to its channel; the final beat releases it.
  always_comb begin
    lock_d    = lock_q;
    lock_ch_d = lock_ch_q;
    if (fire) begin
      lock_d    = !sel_last;
      lock_ch_d = grant;
    end
  end
  // Packet lock registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
    end
  end
`endif
  assign o_out_valid = out_valid_q;
  assign o_out_data  = out_data_q;
  assign o_out_last  = out_last_q;
  assign o_out_ch    = out_ch_q;
endmodule
